// File: rtl/data_cache_controller_if.sv
// ============================================================================
// Module      : data_cache_controller_if
// Description : CPU, storage-array and memory-bus signals of the data cache
//               controller, bundled with controller (slave) / environment
//               (master) views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_cache_controller_if #(
    parameter int INDEX_W = 3,
    parameter int ADDR_W  = 32
);
    logic                cpu_req_i;
    logic [3:0]          cpu_we_i;
    logic [ADDR_W-1:0]   cpu_addr_i;
    logic [31:0]         cpu_wdata_i;
    logic [31:0]         cpu_rdata_o;
    logic                cpu_stall_o;

    logic [INDEX_W-1:0]  cache_addr_o;
    logic [31:0]         cache_wdata_o;
    logic [3:0]          cache_we_o;
    logic [31:0]         cache_rdata_i;

    logic                mem_req_o;
    logic                mem_we_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [31:0]         mem_wdata_o;
    logic [3:0]          mem_wstrb_o;
    logic                mem_ack_i;
    logic [31:0]         mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cache_rdata_i, mem_ack_i, mem_rdata_i,
        output cpu_rdata_o, cpu_stall_o,
        output cache_addr_o, cache_wdata_o, cache_we_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cache_rdata_i, mem_ack_i, mem_rdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        input  cache_addr_o, cache_wdata_o, cache_we_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
endinterface

`default_nettype wire

// File: rtl/data_cache_controller.sv
// ============================================================================
// Module      : data_cache_controller
// Description : Direct-mapped, one-word-line, write-through, no-write-allocate
//               data cache controller. Define DCACHE_STATS_EN to add
//               hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_cache_controller #(
    parameter int INDEX_W = 3,
    parameter int ADDR_W  = 32
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    data_cache_controller_if.slave    bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]               hit_count_o,
    output logic [31:0]               miss_count_o
`endif
);

    localparam int c_LINES = 1 << INDEX_W;
    localparam int c_TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_LINES-1:0]   r_valid;
    logic [c_TAG_W-1:0]   r_tag [c_LINES];

    logic [INDEX_W-1:0]   w_idx;
    logic [c_TAG_W-1:0]   w_tag;
    logic                 w_hit;
    logic                 w_fill;
    logic                 w_stall;
    logic [3:0]           w_cache_we;
    logic [31:0]          w_cache_wdata;
    logic                 w_mem_req;
    logic                 w_mem_we;
    logic [3:0]           w_mem_wstrb;
    logic                 w_unused_addr_bits;

    assign w_idx = bus.cpu_addr_i[INDEX_W+1:2];
    assign w_tag = bus.cpu_addr_i[ADDR_W-1:INDEX_W+2];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused_addr_bits = ^bus.cpu_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_valid <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Tags are only meaningful behind a set valid bit, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tag[w_idx] <= w_tag;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_stall       = 1'b0;
        w_cache_we    = 4'h0;
        w_cache_wdata = bus.cpu_wdata_i;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_wstrb   = 4'h0;
        w_fill        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.cpu_req_i) begin
                    if (bus.cpu_we_i != 4'h0) begin
                        w_stall      = 1'b1;
                        w_next_state = ST_WRITE;
                    end else if (!w_hit) begin
                        w_stall      = 1'b1;
                        w_next_state = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                w_mem_req = 1'b1;
                w_stall   = 1'b1;
                if (bus.mem_ack_i) begin
                    w_cache_we    = 4'hF;
                    w_cache_wdata = bus.mem_rdata_i;
                    w_fill        = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_wstrb = bus.cpu_we_i;
                w_stall     = 1'b1;
                if (bus.mem_ack_i) begin
                    w_stall      = 1'b0;
                    // No write allocate: a store miss only goes to memory.
                    if (w_hit) begin
                        w_cache_we = bus.cpu_we_i;
                    end
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Reset abandons any bus transaction, including an ack arriving now.
        if (rst_i) begin
            w_next_state = ST_IDLE;
            w_stall      = 1'b0;
            w_cache_we   = 4'h0;
            w_mem_req    = 1'b0;
            w_mem_we     = 1'b0;
            w_mem_wstrb  = 4'h0;
            w_fill       = 1'b0;
        end
    end

    assign bus.cpu_rdata_o   = bus.cache_rdata_i;
    assign bus.cpu_stall_o   = w_stall;
    assign bus.cache_addr_o  = w_idx;
    assign bus.cache_wdata_o = w_cache_wdata;
    assign bus.cache_we_o    = w_cache_we;
    assign bus.mem_req_o     = w_mem_req;
    assign bus.mem_we_o      = w_mem_we;
    assign bus.mem_addr_o    = {bus.cpu_addr_i[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata_o   = bus.cpu_wdata_i;
    assign bus.mem_wstrb_o   = w_mem_wstrb;

`ifdef DCACHE_STATS_EN
    logic        r_after_refill;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        w_load_done;
    logic        w_store_done;

    assign w_load_done  = (r_state == ST_IDLE) && bus.cpu_req_i &&
                          (bus.cpu_we_i == 4'h0) && w_hit;
    assign w_store_done = (r_state == ST_WRITE) && bus.mem_ack_i;

    // The hit right after a refill is the tail of the same miss.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_after_refill <= 1'b0;
            r_hit_count    <= 32'd0;
            r_miss_count   <= 32'd0;
        end else begin
            r_after_refill <= w_fill;
            if (w_load_done) begin
                if (r_after_refill) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end else begin
                    r_hit_count  <= r_hit_count + 32'd1;
                end
            end else if (w_store_done) begin
                if (w_hit) begin
                    r_hit_count  <= r_hit_count + 32'd1;
                end else begin
                    r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end

    assign hit_count_o  = r_hit_count;
    assign miss_count_o = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_cache_controller.sv
// ============================================================================
// Module      : tb_data_cache_controller
// Description : Directed, table-driven bench for data_cache_controller with a
//               byte-enabled storage array model. Covers DCACHE_STATS_EN too.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_cache_controller;

    typedef struct {
        logic        rst;
        logic        req;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] mrd;
        logic        e_stall;
        logic        e_mreq;
        logic        e_mwe;
        logic [3:0]  e_wstrb;
        logic [3:0]  e_cwe;
        logic [31:0] e_cwd;
        logic        e_rchk;
        logic [31:0] e_rd;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    logic [31:0] store_mem [8];

    data_cache_controller_if #(.INDEX_W(3), .ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    data_cache_controller #(.INDEX_W(3), .ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus.slave)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-enabled storage array with combinational read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.cache_we_o[b]) begin
                store_mem[bus.cache_addr_o][8*b +: 8] <= bus.cache_wdata_o[8*b +: 8];
            end
        end
    end
    assign bus.cache_rdata_i = store_mem[bus.cache_addr_o];

    function automatic vec_t V(logic rst_v, logic req, logic [3:0] we, logic [31:0] addr,
                               logic [31:0] wdata, logic ack, logic [31:0] mrd,
                               logic st, logic mrq, logic mwe, logic [3:0] ws,
                               logic [3:0] cwe, logic [31:0] cwd, logic rchk, logic [31:0] rd);
        vec_t v;
        v.rst = rst_v; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.ack = ack; v.mrd = mrd; v.e_stall = st; v.e_mreq = mrq; v.e_mwe = mwe;
        v.e_wstrb = ws; v.e_cwe = cwe; v.e_cwd = cwd; v.e_rchk = rchk; v.e_rd = rd;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic bad;
        logic [31:0] exp_maddr;
        @(posedge clk);
        #1;
        rst             = v.rst;
        bus.cpu_req_i   = v.req;
        bus.cpu_we_i    = v.we;
        bus.cpu_addr_i  = v.addr;
        bus.cpu_wdata_i = v.wdata;
        bus.mem_ack_i   = v.ack;
        bus.mem_rdata_i = v.mrd;
        #3;
        exp_maddr = {v.addr[31:2], 2'b00};
        bad = 1'b0;
        if (bus.cpu_stall_o !== v.e_stall) bad = 1'b1;
        if (bus.mem_req_o   !== v.e_mreq)  bad = 1'b1;
        if (bus.mem_we_o    !== v.e_mwe)   bad = 1'b1;
        if (bus.mem_wstrb_o !== v.e_wstrb) bad = 1'b1;
        if (bus.cache_we_o  !== v.e_cwe)   bad = 1'b1;
        if (bus.cache_addr_o !== v.addr[4:2]) bad = 1'b1;
        if ((v.e_cwe != 4'h0) && (bus.cache_wdata_o !== v.e_cwd)) bad = 1'b1;
        if (v.e_rchk && (bus.cpu_rdata_o !== v.e_rd)) bad = 1'b1;
        if (v.e_mreq && (bus.mem_addr_o !== exp_maddr)) bad = 1'b1;
        if (v.e_mreq && v.e_mwe && (bus.mem_wdata_o !== v.wdata)) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("FAIL %s: got stall=%b mreq=%b mwe=%b wstrb=%h cwe=%h cwd=%h rd=%h maddr=%h cidx=%0d; want stall=%b mreq=%b mwe=%b wstrb=%h cwe=%h cwd=%h rd=%h(chk=%b) maddr=%h cidx=%0d",
                     name, bus.cpu_stall_o, bus.mem_req_o, bus.mem_we_o, bus.mem_wstrb_o,
                     bus.cache_we_o, bus.cache_wdata_o, bus.cpu_rdata_o, bus.mem_addr_o,
                     bus.cache_addr_o, v.e_stall, v.e_mreq, v.e_mwe, v.e_wstrb, v.e_cwe,
                     v.e_cwd, v.e_rd, v.e_rchk, exp_maddr, v.addr[4:2]);
        end
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst             = 1'b1;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 4'h0;
        bus.cpu_addr_i  = 32'h0;
        bus.cpu_wdata_i = 32'h0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;

        //        rst req we    addr      wdata         ack mrd           st mrq mwe ws    cwe   cwd           rchk rd
        // reset state
        tbl.push_back(V(1, 0, 4'h0, 32'h00, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(1, 1, 4'h0, 32'h10, 32'h0,        1, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        // load 0x10 miss, refill, re-lookup hit
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        1, 1, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 1, 1, 0, 4'h0, 4'hF, 32'hDEADBEEF, 0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'hDEADBEEF));
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'hDEADBEEF));
        // load 0x30: same index, different tag
        tbl.push_back(V(0, 1, 4'h0, 32'h30, 32'h0,        0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h30, 32'h0,        1, 32'hCAFEF00D, 1, 1, 0, 4'h0, 4'hF, 32'hCAFEF00D, 0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h30, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'hCAFEF00D));
        // 0x10 was evicted
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 1, 1, 0, 4'h0, 4'hF, 32'hDEADBEEF, 0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'hDEADBEEF));
        // store hit, partial strobes
        tbl.push_back(V(0, 1, 4'h3, 32'h10, 32'h00001234, 0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'h3, 32'h10, 32'h00001234, 0, 32'h0,        1, 1, 1, 4'h3, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'h3, 32'h10, 32'h00001234, 1, 32'h0,        0, 1, 1, 4'h3, 4'h3, 32'h00001234, 0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'hDEAD1234));
        // store miss to invalid line: no allocate
        tbl.push_back(V(0, 1, 4'hF, 32'h20, 32'h55AA55AA, 0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'hF, 32'h20, 32'h55AA55AA, 1, 32'h0,        0, 1, 1, 4'hF, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h20, 32'h0,        0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h20, 32'h0,        1, 32'h11112222, 1, 1, 0, 4'h0, 4'hF, 32'h11112222, 0, 32'h0));
        tbl.push_back(V(0, 1, 4'h0, 32'h20, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'h11112222));
        // stray ack in IDLE is ignored
        tbl.push_back(V(0, 0, 4'h0, 32'h00, 32'h0,        1, 32'h77,       0, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(V(0, 0, 4'h0, 32'h00, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Reset during REFILL, then a late ack.
        seq.push_back(V(0, 1, 4'h0, 32'h08, 32'h0,        0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        seq.push_back(V(0, 1, 4'h0, 32'h08, 32'h0,        0, 32'h0,        1, 1, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        seq.push_back(V(1, 1, 4'h0, 32'h08, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        seq.push_back(V(0, 0, 4'h0, 32'h08, 32'h0,        1, 32'hBAD0BAD0, 0, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        // After reset: miss, hit, hit, store miss
        seq.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        seq.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        1, 32'h01020304, 1, 1, 0, 4'h0, 4'hF, 32'h01020304, 0, 32'h0));
        seq.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'h01020304));
        seq.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'h01020304));
        seq.push_back(V(0, 1, 4'h0, 32'h10, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        1, 32'h01020304));
        seq.push_back(V(0, 1, 4'hF, 32'h20, 32'h00000009, 0, 32'h0,        1, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));
        seq.push_back(V(0, 1, 4'hF, 32'h20, 32'h00000009, 1, 32'h0,        0, 1, 1, 4'hF, 4'h0, 32'h0,        0, 32'h0));
        seq.push_back(V(0, 0, 4'h0, 32'h00, 32'h0,        0, 32'h0,        0, 0, 0, 4'h0, 4'h0, 32'h0,        0, 32'h0));

        foreach (seq[i]) apply(seq[i], $sformatf("seq[%0d]", i));

`ifdef DCACHE_STATS_EN
        n_vec++;
        if ((hit_count !== 32'd2) || (miss_count !== 32'd2)) begin
            n_miss++;
            $display("FAIL stats: got hit=%0d miss=%0d; want hit=2 miss=2", hit_count, miss_count);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
